// File: rtl/cache_mem_responder_if.sv
// Line-traffic bus between the cache controller (master) and the memory responder (slave).
interface cache_mem_responder_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] wdata;
  logic              wdata_valid;
  logic              wdata_ready;
  logic [DATA_W-1:0] rdata;
  logic              rdata_valid;
  logic              rdata_last;
  logic              rdata_ready;
  logic              write_done;

  modport master (
    output req_valid, req_write, req_addr, wdata, wdata_valid, rdata_ready,
    input  req_ready, wdata_ready, rdata, rdata_valid, rdata_last, write_done
  );

  modport slave (
    input  req_valid, req_write, req_addr, wdata, wdata_valid, rdata_ready,
    output req_ready, wdata_ready, rdata, rdata_valid, rdata_last, write_done
  );
endinterface

// File: rtl/cache_mem_responder.sv
// Main-memory end of the cache line bus: one refill or writeback at a time, fixed access
// latency, word-per-beat streaming under valid/ready. All bus outputs are registered.
module cache_mem_responder #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned WORDS   = 4,
  parameter int unsigned LINES   = 64,
  parameter int unsigned LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  cache_mem_responder_if.slave bus,
  output logic                 busy,
  output logic [2:0]           state
);

  localparam int unsigned IDX_W  = $clog2(LINES);
  localparam int unsigned BEAT_W = $clog2(WORDS);
  localparam int unsigned LAT_W  = $clog2(LATENCY + 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(WORDS - 1);
  localparam logic [LAT_W-1:0]  LAT_MAX   = LAT_W'(LATENCY);

  typedef enum logic [2:0] {
    StIdle    = 3'b000,
    StRdWait  = 3'b001,
    StRdBurst = 3'b010,
    StWrBurst = 3'b011,
    StWrWait  = 3'b100,
    StWrAck   = 3'b101
  } state_e;

  state_e            st;
  logic [IDX_W-1:0]  idx;
  logic [BEAT_W-1:0] beat;
  logic [BEAT_W-1:0] beat_nxt;
  logic [LAT_W-1:0]  lat;
  logic              mem_we;
  logic [ADDR_W-1:0] req_addr_w;
  logic              unused_addr_hi;

  // Backing store, word-addressed as {line index, beat}; deliberately never reset.
  logic [DATA_W-1:0] mem [LINES*WORDS];

  assign req_addr_w     = bus.req_addr;
  // Upper address bits only alias lines together; they carry no state.
  assign unused_addr_hi = ^req_addr_w[ADDR_W-1:IDX_W];
  assign beat_nxt       = beat + 1'b1;
  // wdata_ready is high exactly while in StWrBurst, so this is the wdata handshake.
  assign mem_we         = (st == StWrBurst) && bus.wdata_valid;
  assign busy           = (st != StIdle);
  assign state          = st;

  // Array write port: one writeback word per accepted beat.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[{idx, beat}] <= bus.wdata;
    end
  end

  // Request FSM with registered bus outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st              <= StIdle;
      idx             <= '0;
      beat            <= '0;
      lat             <= '0;
      bus.req_ready   <= 1'b0;
      bus.wdata_ready <= 1'b0;
      bus.rdata_valid <= 1'b0;
      bus.rdata_last  <= 1'b0;
      bus.rdata       <= '0;
      bus.write_done  <= 1'b0;
    end else begin
      unique case (st)
        StIdle: begin
          bus.req_ready <= 1'b1;
          if (bus.req_valid && bus.req_ready) begin
            idx           <= req_addr_w[IDX_W-1:0];
            beat          <= '0;
            lat           <= '0;
            bus.req_ready <= 1'b0;
            if (bus.req_write) begin
              st              <= StWrBurst;
              bus.wdata_ready <= 1'b1;
            end else begin
              st <= StRdWait;
            end
          end
        end
        StRdWait: begin
          // Counts 0..LATENCY, so the first word appears LATENCY+1 cycles after accept.
          if (lat == LAT_MAX) begin
            st              <= StRdBurst;
            bus.rdata_valid <= 1'b1;
            bus.rdata       <= mem[{idx, beat}];
            bus.rdata_last  <= (beat == BEAT_LAST);
          end else begin
            lat <= lat + 1'b1;
          end
        end
        StRdBurst: begin
          if (bus.rdata_ready) begin
            if (beat == BEAT_LAST) begin
              st              <= StIdle;
              bus.rdata_valid <= 1'b0;
              bus.rdata_last  <= 1'b0;
              bus.rdata       <= '0;
              bus.req_ready   <= 1'b1;
            end else begin
              beat           <= beat_nxt;
              bus.rdata      <= mem[{idx, beat_nxt}];
              bus.rdata_last <= (beat_nxt == BEAT_LAST);
            end
          end
        end
        StWrBurst: begin
          if (bus.wdata_valid) begin
            if (beat == BEAT_LAST) begin
              st              <= StWrWait;
              bus.wdata_ready <= 1'b0;
              lat             <= '0;
            end else begin
              beat <= beat_nxt;
            end
          end
        end
        StWrWait: begin
          if (lat == LAT_MAX) begin
            st             <= StWrAck;
            bus.write_done <= 1'b1;
          end else begin
            lat <= lat + 1'b1;
          end
        end
        StWrAck: begin
          st             <= StIdle;
          bus.write_done <= 1'b0;
          bus.req_ready  <= 1'b1;
        end
        default: st <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench for cache_mem_responder: reset, writeback/refill timing, aliasing,
// read stalls, write gaps and mid-refill reset.
module tb_cache_mem_responder;

  localparam int unsigned LATENCY = 4;
  localparam int unsigned WORDS   = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       busy;
  logic [2:0] state;
  int         n_checks = 0;
  int         n_fails  = 0;
  int         n;

  cache_mem_responder_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  cache_mem_responder #(
    .ADDR_W (32),
    .DATA_W (32),
    .WORDS  (WORDS),
    .LINES  (64),
    .LATENCY(LATENCY)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus),
    .busy   (busy),
    .state  (state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Step to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_line(input logic [31:0] addr, input logic [127:0] line, input bit gaps);
    int k;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = addr;
    tick();
    bus.req_valid = 1'b0;
    check_eq("wr_state_burst", {29'd0, state}, 32'd3);
    check_eq("wr_wdata_ready", {31'd0, bus.wdata_ready}, 32'd1);
    check_eq("wr_req_ready_low", {31'd0, bus.req_ready}, 32'd0);
    for (int b = 0; b < WORDS; b++) begin
      if (gaps) begin
        bus.wdata_valid = 1'b0;
        bus.wdata       = 32'hDEAD_BEEF;
        tick();
      end
      bus.wdata_valid = 1'b1;
      bus.wdata       = line[b*32 +: 32];
      tick();
    end
    bus.wdata_valid = 1'b0;
    bus.wdata       = 32'hDEAD_BEEF;
    check_eq("wr_state_wait", {29'd0, state}, 32'd4);
    check_eq("wr_wdata_ready_off", {31'd0, bus.wdata_ready}, 32'd0);
    k = 0;
    while (!bus.write_done && k < 50) begin
      tick();
      k++;
    end
    check_eq("wr_done_latency", k, LATENCY + 1);
    check_eq("wr_state_ack", {29'd0, state}, 32'd5);
    tick();
    check_eq("wr_done_pulse", {31'd0, bus.write_done}, 32'd0);
    check_eq("wr_req_ready_back", {31'd0, bus.req_ready}, 32'd1);
    check_eq("wr_idle", {29'd0, state}, 32'd0);
  endtask

  task automatic read_line(input logic [31:0] addr, input logic [127:0] line,
                           input int stall_beat, input int stall_n);
    int k;
    bus.rdata_ready = 1'b1;
    bus.req_valid   = 1'b1;
    bus.req_write   = 1'b0;
    bus.req_addr    = addr;
    tick();
    bus.req_valid = 1'b0;
    check_eq("rd_state_wait", {29'd0, state}, 32'd1);
    k = 0;
    while (!bus.rdata_valid && k < 50) begin
      tick();
      k++;
    end
    check_eq("rd_latency", k, LATENCY + 1);
    for (int b = 0; b < WORDS; b++) begin
      if (b == stall_beat) begin
        bus.rdata_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          check_eq("rd_stall_data", bus.rdata, line[b*32 +: 32]);
          check_eq("rd_stall_valid", {31'd0, bus.rdata_valid}, 32'd1);
          tick();
        end
        bus.rdata_ready = 1'b1;
      end
      check_eq("rd_data", bus.rdata, line[b*32 +: 32]);
      check_eq("rd_valid", {31'd0, bus.rdata_valid}, 32'd1);
      check_eq("rd_last", {31'd0, bus.rdata_last}, (b == WORDS - 1) ? 32'd1 : 32'd0);
      check_eq("rd_req_ready_low", {31'd0, bus.req_ready}, 32'd0);
      tick();
    end
    check_eq("rd_valid_off", {31'd0, bus.rdata_valid}, 32'd0);
    check_eq("rd_req_ready_back", {31'd0, bus.req_ready}, 32'd1);
    check_eq("rd_not_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    bus.req_valid   = 1'b0;
    bus.req_write   = 1'b0;
    bus.req_addr    = '0;
    bus.wdata       = '0;
    bus.wdata_valid = 1'b0;
    bus.rdata_ready = 1'b1;

    // Power-up reset held for 3 cycles.
    tick();
    tick();
    tick();
    check_eq("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    check_eq("rst_rdata_valid", {31'd0, bus.rdata_valid}, 32'd0);
    check_eq("rst_write_done", {31'd0, bus.write_done}, 32'd0);
    check_eq("rst_state", {29'd0, state}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;
    #1;
    check_eq("rel_req_ready_pre", {31'd0, bus.req_ready}, 32'd0);
    tick();
    check_eq("rel_req_ready", {31'd0, bus.req_ready}, 32'd1);

    // Writeback then refill of line 5.
    write_line(32'd5, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b0);
    tick();
    read_line(32'd5, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, -1, 0);
    tick();

    // Address 69 aliases line 5; stall on beat 2.
    read_line(32'd69, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 2, 3);
    tick();

    // Gapped writeback to line 7, then refill.
    write_line(32'd7, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 1'b1);
    tick();
    read_line(32'd7, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, -1, 0);
    tick();

    // Reset after beat 1 of a refill of line 5.
    bus.rdata_ready = 1'b1;
    bus.req_valid   = 1'b1;
    bus.req_write   = 1'b0;
    bus.req_addr    = 32'd5;
    tick();
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.rdata_valid && n < 50) begin
      tick();
      n++;
    end
    check_eq("mid_latency", n, LATENCY + 1);
    tick();
    tick();
    check_eq("mid_beat2_data", bus.rdata, 32'hA2);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", {31'd0, bus.rdata_valid}, 32'd0);
    check_eq("mid_rst_last", {31'd0, bus.rdata_last}, 32'd0);
    check_eq("mid_rst_rdata", bus.rdata, 32'd0);
    check_eq("mid_rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    check_eq("mid_rst_state", {29'd0, state}, 32'd0);
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check_eq("mid_rel_req_ready", {31'd0, bus.req_ready}, 32'd1);
    read_line(32'd5, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/cache_mem_responder.md
# cache_mem_responder

Memory-side responder for the cache controller's line traffic. It accepts one refill (read) or eviction writeback (write) request at a time from the cache FSM, models a backing store with fixed access latency, and streams line words back (refill) or absorbs them (writeback) under valid/ready handshakes. It sits between the cache controller and the memory model and serves as the bench's main-memory end.

## Interface
- ADDR_W, 32, line address width
- DATA_W, 32, word width
- WORDS, 4, words per line (power of two, ≥2)
- LINES, 64, backing-store lines (power of two); index = req_addr[log2(LINES)-1:0]
- LATENCY, 4, access delay in cycles (≥1)

- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_write  in  1  1 = writeback, 0 = refill; sampled at accept
- req_addr  in  ADDR_W  line address; sampled at accept
- wdata  in  DATA_W  writeback word
- wdata_valid  in  1  wdata present
- wdata_ready  out  1  responder takes wdata this cycle
- rdata  out  DATA_W  refill word
- rdata_valid  out  1  rdata present
- rdata_last  out  1  rdata is the final word of the line
- rdata_ready  in  1  cache takes rdata this cycle
- write_done  out  1  one-cycle writeback completion pulse
- busy  out  1  state ≠ IDLE
- state  out  3  current state, debug

## Operation
- States: IDLE=000, WWAIT... encodings: IDLE=000, RD_WAIT=001, RD_BURST=010, WR_BURST=011, WR_WAIT=100, WR_ACK=101.
- Accept: req_valid && req_ready at an edge; latch req_write, index; clear beat counter (log2(WORDS) bits) and latency counter.
- IDLE: req_ready=1. Accept with req_write=0 → RD_WAIT; req_write=1 → WR_BURST.
- RD_WAIT: count LATENCY cycles, then → RD_BURST.
- RD_BURST: rdata_valid=1, rdata=mem[idx][beat]; beat advances only on rdata_valid && rdata_ready; rdata, rdata_last stable while stalled. rdata_last=1 only when beat=WORDS-1. Transfer of last beat → IDLE.
- WR_BURST: wdata_ready=1; each wdata_valid && wdata_ready writes mem[idx][beat], beat++. Beat WORDS-1 written → WR_WAIT. Gaps in wdata_valid stall the burst indefinitely.
- WR_WAIT: count LATENCY cycles → WR_ACK.
- WR_ACK: write_done=1 for exactly one cycle → IDLE.
- req_ready=0 in every non-IDLE state; one outstanding request maximum, no request queueing.
- Index wraps: addresses differing by a multiple of LINES alias to the same line.
- Backing array is not reset; contents undefined at power-up and preserved across reset.

## Timing
- Reset (reset_n low, async): state=IDLE, counters 0, req_ready=0, wdata_ready=0, rdata_valid=0, rdata_last=0, rdata=0, write_done=0, busy=0. req_ready rises at the first rising edge after reset_n deasserts.
- All outputs registered or decoded from registered state only; no combinational path from inputs to outputs.
- Refill: accept at edge E → rdata_valid first high in the cycle after edge E+LATENCY+1 (1 cycle into RD_WAIT entry plus LATENCY); with rdata_ready held high, one word per cycle, WORDS cycles; req_ready high the cycle after the last beat edge.
- Writeback: accept at edge E → wdata_ready high from cycle after E; last beat at edge L → write_done high in cycle after edge L+LATENCY+1; req_ready high the following cycle.
- Back-to-back: minimum one IDLE cycle between requests.
- Reset mid-operation: abort immediately; words already written in a partial writeback remain in the array; no write_done; a partial refill is not resumed.

## Test plan
- Reset: hold reset_n low 3 cycles → req_ready=0, rdata_valid=0, write_done=0, state=000; first edge after release → req_ready=1.
- Writeback addr 5, words 0xA0..0xA3, wdata_valid always high, LATENCY=4 → 4 beats on consecutive cycles, write_done single pulse at required cycle, req_ready back next cycle.
- Refill addr 5 → rdata_valid at required cycle, words 0xA0,0xA1,0xA2,0xA3, rdata_last only on 0xA3.
- Refill addr 69 (aliases 5) with rdata_ready low 3 cycles on beat 2 → 0xA2 held stable, no dropped or duplicated words.
- Writeback with wdata_valid gaps (valid every other cycle) words 0xB0..0xB3 to addr 7 → only valid beats taken; refill addr 7 returns 0xB0..0xB3.
- Reset asserted after beat 1 of a refill → all outputs zero, state IDLE; new refill of same addr returns full line from beat 0.
